// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared constants for the fetch stage.
// Holds reset PC, bubble instruction and alignment masks.
package if_stage_pkg;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] NOP_INST   = 32'h0000_0013;
    localparam logic [31:0] INST_ALIGN = 32'hFFFF_FFFC;
    localparam logic [31:0] JALR_MASK  = 32'hFFFF_FFFE;
    localparam logic [31:0] PC_STEP    = 32'h0000_0004;

    typedef enum logic [1:0] {
        SEL_SEQ  = 2'b00,
        SEL_JALR = 2'b01,
        SEL_IMM  = 2'b10
    } tgt_sel_e;

    function automatic logic [31:0] align_inst(
        input logic [31:0] a
    );
        return a & INST_ALIGN;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// if_stage_if: redirect, stall, imem and IF/ID bundle.
// master = EX/hazard/imem side, slave = if_stage.
interface if_stage_if;
    import if_stage_pkg::*;

    logic        stall;
    logic        flush;
    logic        pc_sel;
    logic        npc_sel;
    logic [31:0] pc_imm_ex;
    logic [31:0] res_ex;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc_if;
    logic [31:0] pc_id;
    logic [31:0] inst_id;
    logic        valid_id;
    logic        flush_idex;
    logic        misalign_err;
    logic        redirect_err;

    modport master (
        output stall, flush, pc_sel, npc_sel,
        output pc_imm_ex, res_ex, imem_rdata,
        input  imem_addr, pc_if, pc_id, inst_id,
        input  valid_id, flush_idex,
        input  misalign_err, redirect_err
    );

    modport slave (
        input  stall, flush, pc_sel, npc_sel,
        input  pc_imm_ex, res_ex, imem_rdata,
        output imem_addr, pc_if, pc_id, inst_id,
        output valid_id, flush_idex,
        output misalign_err, redirect_err
    );

endinterface

// File: rtl/if_stage_pc_next_mux.sv
// if_stage_pc_next_mux: redirect target select.
// In: pc, flush, selects, targets. Out: aligned target, error flags.
module if_stage_pc_next_mux
    import if_stage_pkg::*;
(
    input  logic [31:0] pc_if,
    input  logic        flush,
    input  logic        pc_sel,
    input  logic        npc_sel,
    input  logic [31:0] pc_imm_ex,
    input  logic [31:0] res_ex,
    output logic [31:0] target,
    output logic        misalign,
    output logic        bad_redirect
);

    tgt_sel_e    sel;
    logic [31:0] raw;

    always_comb begin
        sel = SEL_SEQ;
        if (npc_sel) begin
            sel = SEL_IMM;
        end else if (pc_sel) begin
            sel = SEL_JALR;
        end
    end

    always_comb begin
        raw = pc_if + PC_STEP;
        unique case (sel)
            SEL_IMM:  raw = pc_imm_ex;
            SEL_JALR: raw = res_ex & JALR_MASK;
            default:  raw = pc_if + PC_STEP;
        endcase
    end

    // Flags only mean something when EX is actually redirecting.
    always_comb begin
        target       = align_inst(raw);
        misalign     = flush & raw[1];
        bad_redirect = flush & (pc_sel ~^ npc_sel);
    end

endmodule

// File: rtl/if_stage.sv
// if_stage: PC register, IF/ID register, redirect handling.
// Ports: clk, rst_cpu (sync, active-high), bus (slave bundle).
module if_stage
    import if_stage_pkg::*;
(
    input logic   clk,
    input logic   rst_cpu,
    if_stage_if.slave bus
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_id_q, pc_id_d;
    logic [31:0] inst_q, inst_d;
    logic        valid_q, valid_d;
    logic        mis_q, mis_d;
    logic        rerr_q, rerr_d;

    logic [31:0] target;
    logic        misalign;
    logic        bad_redirect;

    if_stage_pc_next_mux u_mux (
        .pc_if        (pc_q),
        .flush        (bus.flush),
        .pc_sel       (bus.pc_sel),
        .npc_sel      (bus.npc_sel),
        .pc_imm_ex    (bus.pc_imm_ex),
        .res_ex       (bus.res_ex),
        .target       (target),
        .misalign     (misalign),
        .bad_redirect (bad_redirect)
    );

    always_comb begin
        pc_d = pc_q;
        if (bus.flush) begin
            pc_d = target;
        end else if (!bus.stall) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    // Flush beats stall: the held ID instruction is wrong-path.
    always_comb begin
        pc_id_d = pc_id_q;
        inst_d  = inst_q;
        valid_d = valid_q;
        if (bus.flush) begin
            pc_id_d = '0;
            inst_d  = NOP_INST;
            valid_d = 1'b0;
        end else if (!bus.stall) begin
            pc_id_d = pc_q;
            inst_d  = bus.imem_rdata;
            valid_d = 1'b1;
        end
    end

    always_comb begin
        mis_d  = mis_q | misalign;
        rerr_d = rerr_q | bad_redirect;
    end

    always_ff @(posedge clk) begin
        if (rst_cpu) begin
            pc_q    <= RESET_PC;
            pc_id_q <= '0;
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
            rerr_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            pc_id_q <= pc_id_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
            mis_q   <= mis_d;
            rerr_q  <= rerr_d;
        end
    end

    assign bus.imem_addr    = pc_q;
    assign bus.pc_if        = pc_q;
    assign bus.pc_id        = pc_id_q;
    assign bus.inst_id      = inst_q;
    assign bus.valid_id     = valid_q;
    assign bus.flush_idex   = bus.flush & ~rst_cpu;
    assign bus.misalign_err = mis_q;
    assign bus.redirect_err = rerr_q;

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed checks of the fetch stage.
// Instruction ROM returns 0x1000_0000 | address.
module tb_if_stage;

    logic clk = 1'b0;
    logic rst_cpu;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    if_stage_if bus ();

    if_stage dut (
        .clk     (clk),
        .rst_cpu (rst_cpu),
        .bus     (bus.slave)
    );

    assign bus.imem_rdata = 32'h1000_0000 | bus.imem_addr;

    task automatic chk(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.flush   = 1'b0;
        bus.stall   = 1'b0;
        bus.pc_sel  = 1'b0;
        bus.npc_sel = 1'b0;
    endtask

    task automatic jump(input logic [31:0] t);
        bus.flush     = 1'b1;
        bus.npc_sel   = 1'b1;
        bus.pc_imm_ex = t;
        step();
        idle();
    endtask

    initial begin
        rst_cpu       = 1'b1;
        bus.pc_imm_ex = '0;
        bus.res_ex    = '0;
        idle();
        #1;
        chk("rst_fidx", {31'd0, bus.flush_idex}, 32'd0);
        step();
        step();
        chk("rst_pc", bus.pc_if, 32'h0);
        chk("rst_pcid", bus.pc_id, 32'h0);
        chk("rst_inst", bus.inst_id, 32'h13);
        chk("rst_vld", {31'd0, bus.valid_id}, 32'd0);
        chk("rst_mis", {31'd0, bus.misalign_err}, 32'd0);
        chk("rst_rerr", {31'd0, bus.redirect_err}, 32'd0);
        rst_cpu = 1'b0;

        chk("seq_addr0", bus.imem_addr, 32'h0);
        step();
        chk("seq_pc4", bus.pc_if, 32'h4);
        chk("seq_inst0", bus.inst_id, 32'h1000_0000);
        chk("seq_vld", {31'd0, bus.valid_id}, 32'd1);
        step();
        chk("seq_pc8", bus.pc_if, 32'h8);
        chk("seq_pcid4", bus.pc_id, 32'h4);
        chk("seq_inst4", bus.inst_id, 32'h1000_0004);
        step();
        chk("seq_pcC", bus.pc_if, 32'hC);
        for (int i = 0; i < 5; i++) step();
        chk("seq_pc20", bus.pc_if, 32'h20);

        bus.flush     = 1'b1;
        bus.npc_sel   = 1'b1;
        bus.pc_imm_ex = 32'h100;
        #1;
        chk("br_fidx", {31'd0, bus.flush_idex}, 32'd1);
        step();
        idle();
        chk("br_pc", bus.pc_if, 32'h100);
        chk("br_inst", bus.inst_id, 32'h13);
        chk("br_vld", {31'd0, bus.valid_id}, 32'd0);
        chk("br_pcid", bus.pc_id, 32'h0);
        step();
        chk("br_pc104", bus.pc_if, 32'h104);
        chk("br_pcid", bus.pc_id, 32'h100);
        chk("br_inst2", bus.inst_id, 32'h1000_0100);
        chk("br_vld2", {31'd0, bus.valid_id}, 32'd1);
        chk("br_rerr", {31'd0, bus.redirect_err}, 32'd0);

        bus.pc_sel = 1'b1;
        bus.res_ex = 32'h700;
        step();
        idle();
        chk("nosel_pc", bus.pc_if, 32'h108);

        bus.flush  = 1'b1;
        bus.pc_sel = 1'b1;
        bus.res_ex = 32'h203;
        step();
        idle();
        chk("jr_pc", bus.pc_if, 32'h200);
        chk("jr_mis", {31'd0, bus.misalign_err}, 32'd1);
        step();
        chk("jr_mis_stk", {31'd0, bus.misalign_err}, 32'd1);
        rst_cpu = 1'b1;
        step();
        rst_cpu = 1'b0;
        chk("jr_mis_clr", {31'd0, bus.misalign_err}, 32'd0);
        chk("jr_rst_pc", bus.pc_if, 32'h0);

        bus.flush  = 1'b1;
        bus.pc_sel = 1'b1;
        bus.res_ex = 32'h305;
        step();
        idle();
        chk("jr_lsb_pc", bus.pc_if, 32'h304);
        chk("jr_lsb_mis", {31'd0, bus.misalign_err}, 32'd0);

        jump(32'h3C);
        step();
        chk("st_pc0", bus.pc_if, 32'h40);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("st_pc", bus.pc_if, 32'h40);
            chk("st_pcid", bus.pc_id, 32'h3C);
            chk("st_inst", bus.inst_id, 32'h1000_003C);
        end
        bus.flush     = 1'b1;
        bus.npc_sel   = 1'b1;
        bus.pc_imm_ex = 32'h80;
        step();
        idle();
        chk("stfl_pc", bus.pc_if, 32'h80);
        chk("stfl_inst", bus.inst_id, 32'h13);
        chk("stfl_vld", {31'd0, bus.valid_id}, 32'd0);

        jump(32'hFFFF_FFF8);
        step();
        chk("wr_pcfc", bus.pc_if, 32'hFFFF_FFFC);
        step();
        chk("wr_pc0", bus.pc_if, 32'h0);

        bus.flush = 1'b1;
        step();
        idle();
        chk("ne_pc", bus.pc_if, 32'h4);
        chk("ne_rerr", {31'd0, bus.redirect_err}, 32'd1);
        chk("ne_vld", {31'd0, bus.valid_id}, 32'd0);

        rst_cpu = 1'b1;
        step();
        rst_cpu = 1'b0;
        chk("bs_rerr0", {31'd0, bus.redirect_err}, 32'd0);
        bus.flush     = 1'b1;
        bus.pc_sel    = 1'b1;
        bus.npc_sel   = 1'b1;
        bus.pc_imm_ex = 32'h300;
        bus.res_ex    = 32'h500;
        step();
        idle();
        chk("bs_pc", bus.pc_if, 32'h300);
        chk("bs_rerr", {31'd0, bus.redirect_err}, 32'd1);

        step();
        rst_cpu       = 1'b1;
        bus.flush     = 1'b1;
        bus.npc_sel   = 1'b1;
        bus.pc_imm_ex = 32'h100;
        #1;
        chk("rf_fidx", {31'd0, bus.flush_idex}, 32'd0);
        step();
        chk("rf_pc", bus.pc_if, 32'h0);
        chk("rf_vld", {31'd0, bus.valid_id}, 32'd0);
        chk("rf_inst", bus.inst_id, 32'h13);
        chk("rf_rerr", {31'd0, bus.redirect_err}, 32'd0);
        idle();
        rst_cpu = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_err);
        $finish;
    end

endmodule
